// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: source select, load size and FSM state.
package wb_pkg;

    typedef enum logic [1:0] {
        ALU = 2'd0,
        MEM = 2'd1,
        PC4 = 2'd2,
        IMM = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        B = 2'd0,
        H = 2'd1,
        W = 2'd2
    } ld_size_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Load formatter: picks the byte/half lane from the raw load word and extends it to XLEN.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] ld_value
);

    logic [31:0] word_v;
    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        word_v = mem_rdata[31:0];
        case (addr_lo)
            2'd0:    byte_v = word_v[7:0];
            2'd1:    byte_v = word_v[15:8];
            2'd2:    byte_v = word_v[23:16];
            default: byte_v = word_v[31:24];
        endcase
        half_v = addr_lo[1] ? word_v[31:16] : word_v[15:0];

        // Size casts of signed operands sign-extend; word loads extend from bit 31 on RV64.
        case (ld_size_e'(ld_size))
            B:       ld_value = ld_unsigned ? XLEN'(byte_v) : XLEN'($signed(byte_v));
            H:       ld_value = ld_unsigned ? XLEN'(half_v) : XLEN'($signed(half_v));
            default: ld_value = ld_unsigned ? XLEN'(word_v) : XLEN'($signed(word_v));
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: four-source select, variable-latency load wait, registered RF write port.
// Optional bypass/hazard outputs are enabled by defining WB_FWD_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_wb_sel,
    input  logic              in_reg_write,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_pc_plus4,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    input  logic [1:0]        in_addr_lo,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              busy
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic              fwd_pending
`endif
);

    wb_state_e         state_q, state_d;
    logic              reg_write_q, reg_write_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_unsigned_q, ld_unsigned_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

    logic [XLEN-1:0]   sel_value;
    logic [XLEN-1:0]   ld_value;
    logic              accept;

    wb_load_align #(.XLEN(XLEN)) u_align (
        .mem_rdata   (mem_rdata),
        .ld_size     (ld_size_q),
        .ld_unsigned (ld_unsigned_q),
        .addr_lo     (addr_lo_q),
        .ld_value    (ld_value)
    );

    assign in_ready = (state_q != WAIT_MEM);
    assign accept   = in_valid && in_ready;

    always_comb begin
        case (wb_sel_e'(in_wb_sel))
            ALU:     sel_value = in_alu_result;
            PC4:     sel_value = in_pc_plus4;
            IMM:     sel_value = in_imm;
            default: sel_value = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        reg_write_d   = reg_write_q;
        rd_d          = rd_q;
        ld_size_d     = ld_size_q;
        ld_unsigned_d = ld_unsigned_q;
        addr_lo_d     = addr_lo_q;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;

        case (state_q)
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d    = WRITE;
                    rf_waddr_d = rd_q;
                    rf_wdata_d = ld_value;
                end
            end
            default: begin
                if (accept) begin
                    reg_write_d   = in_reg_write;
                    rd_d          = in_rd;
                    ld_size_d     = in_ld_size;
                    ld_unsigned_d = in_ld_unsigned;
                    addr_lo_d     = in_addr_lo;
                    if (wb_sel_e'(in_wb_sel) == MEM) begin
                        state_d = WAIT_MEM;
                    end else begin
                        state_d    = WRITE;
                        rf_waddr_d = in_rd;
                        rf_wdata_d = sel_value;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        // x0 writes still occupy the WRITE cycle, they just never assert the enable.
        rf_we_d = (state_d == WRITE) && reg_write_d && (rd_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            reg_write_q   <= 1'b0;
            rd_q          <= '0;
            ld_size_q     <= 2'd0;
            ld_unsigned_q <= 1'b0;
            addr_lo_q     <= 2'd0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            reg_write_q   <= reg_write_d;
            rd_q          <= rd_d;
            ld_size_q     <= ld_size_d;
            ld_unsigned_q <= ld_unsigned_d;
            addr_lo_q     <= addr_lo_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = (state_q != IDLE);

`ifdef WB_FWD_EN
    assign fwd_valid   = rf_we_q;
    assign fwd_rd      = rf_waddr_q;
    assign fwd_data    = rf_wdata_q;
    assign fwd_pending = (state_q == WAIT_MEM) && reg_write_q && (rd_q != '0);
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized traffic against a behavioural model.
module tb_wb_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_wb_sel = 2'd0;
    logic              in_reg_write = 1'b0;
    logic [REG_AW-1:0] in_rd = '0;
    logic [XLEN-1:0]   in_alu_result = '0;
    logic [XLEN-1:0]   in_pc_plus4 = '0;
    logic [XLEN-1:0]   in_imm = '0;
    logic [1:0]        in_ld_size = 2'd0;
    logic              in_ld_unsigned = 1'b0;
    logic [1:0]        in_addr_lo = 2'd0;
    logic              mem_rvalid = 1'b0;
    logic [XLEN-1:0]   mem_rdata = '0;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              busy;
`ifdef WB_FWD_EN
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [XLEN-1:0]   fwd_data;
    logic              fwd_pending;
`endif

    always #5 clk = ~clk;

    wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_wb_sel      (in_wb_sel),
        .in_reg_write   (in_reg_write),
        .in_rd          (in_rd),
        .in_alu_result  (in_alu_result),
        .in_pc_plus4    (in_pc_plus4),
        .in_imm         (in_imm),
        .in_ld_size     (in_ld_size),
        .in_ld_unsigned (in_ld_unsigned),
        .in_addr_lo     (in_addr_lo),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .busy           (busy)
`ifdef WB_FWD_EN
        ,
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .fwd_pending    (fwd_pending)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a pending-load record plus the expected write-port contents.
    bit          m_wait = 0;
    bit          m_wr = 0;
    bit          m_we = 0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    bit          p_rw = 0;
    logic [4:0]  p_rd = '0;
    logic [1:0]  p_size = '0;
    bit          p_uns = 0;
    logic [1:0]  p_addr = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] size,
                                             input bit uns, input logic [1:0] a);
        logic [31:0] v;
        int          bits;
        if (size == 2'd0) begin
            v    = (w >> (8 * a)) & 32'hFF;
            bits = 8;
        end else if (size == 2'd1) begin
            v    = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
            bits = 16;
        end else begin
            v    = w;
            bits = 32;
        end
        if (!uns && bits < 32 && v[bits-1])
            v = v | (32'hFFFF_FFFF << bits);
        return v;
    endfunction

    function automatic logic [31:0] src_val(input logic [1:0] sel);
        if (sel == 2'd0) return in_alu_result;
        if (sel == 2'd2) return in_pc_plus4;
        return in_imm;
    endfunction

    task automatic check_outputs(input string ctx);
        check_eq({ctx, ".rf_we"}, rf_we, m_we);
        check_eq({ctx, ".rf_waddr"}, rf_waddr, m_waddr);
        check_eq({ctx, ".rf_wdata"}, rf_wdata, m_wdata);
        check_eq({ctx, ".in_ready"}, in_ready, !m_wait);
        check_eq({ctx, ".busy"}, busy, m_wait || m_wr);
`ifdef WB_FWD_EN
        check_eq({ctx, ".fwd_valid"}, fwd_valid, m_we);
        check_eq({ctx, ".fwd_rd"}, fwd_rd, m_waddr);
        check_eq({ctx, ".fwd_data"}, fwd_data, m_wdata);
        check_eq({ctx, ".fwd_pending"}, fwd_pending, m_wait && p_rw && (p_rd != 0));
`endif
    endtask

    // Advance one clock: the model consumes the inputs presented before the edge.
    task automatic tick(input string ctx);
        bit          n_wait, n_wr, n_we;
        logic [4:0]  n_waddr;
        logic [31:0] n_wdata;
        n_wait  = m_wait;
        n_wr    = 0;
        n_we    = 0;
        n_waddr = m_waddr;
        n_wdata = m_wdata;
        if (m_wait) begin
            if (mem_rvalid) begin
                n_wait  = 0;
                n_wr    = 1;
                n_waddr = p_rd;
                n_wdata = fmt_load(mem_rdata, p_size, p_uns, p_addr);
                n_we    = p_rw && (p_rd != 0);
            end
        end else if (in_valid) begin
            if (in_wb_sel == 2'd1) begin
                n_wait = 1;
                p_rw   = in_reg_write;
                p_rd   = in_rd;
                p_size = in_ld_size;
                p_uns  = in_ld_unsigned;
                p_addr = in_addr_lo;
            end else begin
                n_wr    = 1;
                n_waddr = in_rd;
                n_wdata = src_val(in_wb_sel);
                n_we    = in_reg_write && (in_rd != 0);
            end
        end
        @(posedge clk);
        #1;
        m_wait  = n_wait;
        m_wr    = n_wr;
        m_we    = n_we;
        m_waddr = n_waddr;
        m_wdata = n_wdata;
        check_outputs(ctx);
    endtask

    task automatic do_reset(input string ctx);
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_wait = 0; m_wr = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
        p_rw = 0; p_rd = '0;
        check_outputs({ctx, ".async"});
        @(posedge clk);
        #1;
        check_outputs({ctx, ".held"});
        rst = 1'b0;
    endtask

    task automatic drive_op(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val);
        in_valid      = 1'b1;
        in_wb_sel     = sel;
        in_reg_write  = 1'b1;
        in_rd         = rd;
        in_alu_result = (sel == 2'd0) ? val : 32'hDEAD_0000;
        in_pc_plus4   = (sel == 2'd2) ? val : 32'hDEAD_0002;
        in_imm        = (sel == 2'd3) ? val : 32'hDEAD_0003;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [1:0] size, input bit uns,
                              input logic [1:0] a);
        in_valid       = 1'b1;
        in_wb_sel      = 2'd1;
        in_reg_write   = 1'b1;
        in_rd          = rd;
        in_ld_size     = size;
        in_ld_unsigned = uns;
        in_addr_lo     = a;
    endtask

    initial begin
        do_reset("reset");
        check_eq("reset.rf_we", rf_we, 1'b0);
        check_eq("reset.in_ready", in_ready, 1'b1);

        // Single ALU op
        drive_op(2'd0, 5'd5, 32'h0000_1234);
        tick("alu");
        in_valid = 1'b0;
        check_eq("alu.we", rf_we, 1'b1);
        check_eq("alu.addr", rf_waddr, 5'd5);
        check_eq("alu.data", rf_wdata, 32'h0000_1234);
        tick("alu_after");
        check_eq("alu.we_drop", rf_we, 1'b0);

        // Back-to-back PC4, IMM, ALU
        drive_op(2'd2, 5'd1, 32'h0000_0104);
        tick("b2b_pc4");
        check_eq("b2b.pc4_data", rf_wdata, 32'h0000_0104);
        drive_op(2'd3, 5'd2, 32'hFFFF_F000);
        tick("b2b_imm");
        check_eq("b2b.imm_data", rf_wdata, 32'hFFFF_F000);
        drive_op(2'd0, 5'd3, 32'h0000_0007);
        tick("b2b_alu");
        check_eq("b2b.alu_data", rf_wdata, 32'h0000_0007);
        check_eq("b2b.alu_we", rf_we, 1'b1);
        in_valid = 1'b0;
        tick("b2b_end");

        // Signed then unsigned byte load, response three cycles after accept
        for (int u = 0; u < 2; u++) begin
            drive_load(5'd6, 2'd0, u[0], 2'd2);
            tick("lb_acc");
            in_valid = 1'b0;
            check_eq("lb.ready_wait", in_ready, 1'b0);
            tick("lb_w1");
            tick("lb_w2");
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h0080_0000;
            tick("lb_resp");
            mem_rvalid = 1'b0;
            check_eq("lb.data", rf_wdata, u ? 32'h0000_0080 : 32'hFFFF_FF80);
            check_eq("lb.we", rf_we, 1'b1);
            tick("lb_end");
        end

        // Half load with a stray response in the accept cycle
        drive_load(5'd7, 2'd1, 1'b0, 2'd2);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick("lh_acc");
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        check_eq("lh.still_wait", in_ready, 1'b0);
        check_eq("lh.no_we", rf_we, 1'b0);
        tick("lh_w1");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8001_0000;
        tick("lh_resp");
        mem_rvalid = 1'b0;
        check_eq("lh.data", rf_wdata, 32'hFFFF_8001);
        tick("lh_end");

        // Write to x0
        drive_op(2'd0, 5'd0, 32'h0000_0055);
        tick("x0");
        in_valid = 1'b0;
        check_eq("x0.we", rf_we, 1'b0);
        check_eq("x0.busy", busy, 1'b1);
        tick("x0_end");

        // Reset while waiting for a load
        drive_load(5'd9, 2'd2, 1'b0, 2'd0);
        tick("rstw_acc");
        in_valid = 1'b0;
        tick("rstw_w1");
`ifdef WB_FWD_EN
        check_eq("rstw.pending_before", fwd_pending, 1'b1);
`endif
        do_reset("rstw");
`ifdef WB_FWD_EN
        check_eq("rstw.pending_after", fwd_pending, 1'b0);
`endif
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick("rstw_resp");
        mem_rvalid = 1'b0;
        check_eq("rstw.no_we", rf_we, 1'b0);
        check_eq("rstw.idle", busy, 1'b0);
        tick("rstw_end");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rand_rst");
            end
            in_valid       = ($urandom_range(0, 3) != 0);
            in_wb_sel      = 2'($urandom_range(0, 3));
            in_reg_write   = ($urandom_range(0, 7) != 0);
            in_rd          = 5'($urandom_range(0, 31));
            in_alu_result  = $urandom;
            in_pc_plus4    = $urandom;
            in_imm         = $urandom;
            in_ld_size     = 2'($urandom_range(0, 3));
            in_ld_unsigned = 1'($urandom_range(0, 1));
            in_addr_lo     = 2'($urandom_range(0, 3));
            mem_rvalid     = ($urandom_range(0, 2) == 0);
            mem_rdata      = $urandom;
            tick("rand");
        end
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised writeback stage for the RISC-V core. It replaces the single-bit ALU/memory writeback select with a four-source select covering ALU, load data, PC+4 and immediate. It waits for variable-latency load responses and aligns and sign-/zero-extends sub-word loads. It drives the register-file write port from registered state, sitting between the MEM stage and the register file.

## Interface
- `XLEN`, default 32: datapath width; must be 32 or 64.
- `REG_AW`, default 5: register address width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: MEM stage presents an instruction.
- `in_ready` out 1: stage can accept; transfer occurs when `in_valid && in_ready`.
- `in_wb_sel` in 2: source select; 0 ALU, 1 MEM, 2 PC4, 3 IMM.
- `in_reg_write` in 1: instruction writes `rd`.
- `in_rd` in REG_AW: destination register.
- `in_alu_result`, `in_pc_plus4`, `in_imm` in XLEN each: candidate sources.
- `in_ld_size` in 2: 0 byte, 1 half, 2 word, 3 reserved (treated as word).
- `in_ld_unsigned` in 1: zero-extend when 1, sign-extend when 0.
- `in_addr_lo` in 2: load byte offset.
- `mem_rvalid` in 1: load data valid, a single-cycle pulse.
- `mem_rdata` in XLEN: raw load word.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out REG_AW: write address.
- `rf_wdata` out XLEN: write data.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, WAIT_MEM, WRITE.
- `in_ready` = state != WAIT_MEM.
- Acceptance in IDLE or WRITE captures all `in_*` fields.
  - If `in_wb_sel`==MEM, next state is WAIT_MEM.
  - Otherwise the selected source is registered into the data register and next state is WRITE.
- WAIT_MEM: on `mem_rvalid`, the formatted load value is registered and next state is WRITE. Without `mem_rvalid`, the stage holds with no timeout.
- WRITE: exactly one write cycle. Next state is WRITE if a new non-load is accepted, WAIT_MEM if a new load is accepted, else IDLE.
- `rf_we` = (state==WRITE) && captured `reg_write` && captured `rd`!=0. Writes to x0 still consume the WRITE cycle.
- `rf_waddr` and `rf_wdata` are registered values and hold their last value outside WRITE.
- Load formatting:
  - Byte uses lane `addr_lo`.
  - Half uses lane `addr_lo[1]`.
  - Word ignores `addr_lo`.
  - Result is extended to XLEN per `ld_unsigned`.
  - When XLEN=64, word loads also extend from bit 31.
- `mem_rvalid` outside WAIT_MEM is ignored. This includes the cycle in which a load is accepted, so a response must arrive at least one cycle after acceptance.
- Reset values: state IDLE, `rf_we` 0, `rf_waddr` 0, `rf_wdata` 0, `busy` 0, `in_ready` 1.
- Reset asserted mid-WAIT_MEM drops the pending load and produces no write after release.

## Timing
- Non-load: accepted at edge N; `rf_we` is high during cycle N+1.
- Back-to-back non-loads sustain one write per cycle.
- Load: accepted at edge N, with `mem_rvalid` sampled at edge M>N; `rf_we` is high during cycle M+1.
- `in_ready` is low for every cycle spent in WAIT_MEM.
- All outputs except `in_ready` derive only from registers. `in_ready` depends only on state.

## Configuration
- `WB_FWD_EN` defined: adds these outputs:
  - `fwd_valid` = `rf_we`, with `fwd_rd` = `rf_waddr` and `fwd_data` = `rf_wdata`, for the decode bypass network.
  - `fwd_pending`, high in WAIT_MEM when the captured `reg_write` is set and `rd`!=0, so the hazard unit stalls dependents.
- `WB_FWD_EN` undefined: these four ports do not exist; all other behaviour is identical.

## Structure
- Package `wb_pkg` holds:
  - enum `wb_sel_e` (ALU=0, MEM=1, PC4=2, IMM=3);
  - enum `ld_size_e` (B=0, H=1, W=2);
  - enum `wb_state_e` (IDLE, WAIT_MEM, WRITE).
- One combinational sub-module, `wb_load_align`, maps (`mem_rdata`, `ld_size`, `ld_unsigned`, `addr_lo`) to the extended value.

## Test plan
- Reset, then ALU op with rd=5 and `in_alu_result`=0x0000_1234 accepted at edge 1. Required: `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234 during cycle 2 only.
- Three back-to-back ops on consecutive cycles: PC4 (pc+4=0x104, rd=1), IMM (0xFFFF_F000, rd=2), ALU (7, rd=3). Required: three consecutive `rf_we` cycles with those values in order; `in_ready` stays 1.
- Signed byte load, `addr_lo`=2, `mem_rdata`=0x0080_0000, `mem_rvalid` three cycles after accept. Required: `in_ready`=0 while waiting, then `rf_wdata`=0xFFFF_FF80. The same case with `in_ld_unsigned`=1 gives 0x0000_0080.
- Half load, `addr_lo`=2, `mem_rdata`=0x8001_0000, signed. Required: 0xFFFF_8001. `mem_rvalid` pulsed in the accept cycle is ignored, and the stage keeps waiting.
- Op with rd=0 and `reg_write`=1. Required: WRITE cycle occurs but `rf_we`=0.
- Reset asserted during WAIT_MEM, then `mem_rvalid` after release. Required: no `rf_we`; state IDLE. With `WB_FWD_EN` defined, `fwd_pending`=1 before the reset and 0 after it.
